// File: rtl/interrupt_controller_pkg.sv
// =============================================================================
// interrupt_controller_pkg : shared constants and FSM state type
// Revision 1.0
// =============================================================================
`default_nettype none

package interrupt_controller_pkg;

    localparam int IRQ_LINES = 8;
    localparam int IRQ_ID_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_t;

endpackage

`default_nettype wire

// File: rtl/interrupt_controller_irq_sync_edge.sv
// =============================================================================
// irq_sync_edge : multi-flop synchroniser with rising-edge detect for one line
// Revision 1.0
// =============================================================================
`default_nettype none

module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic ph1,
    input  logic reset,
    input  logic din,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] chain;
    logic                   s_d;

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            chain <= '0;
            s_d   <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
            s_d   <= chain[SYNC_STAGES-1];
        end
    end

    assign s    = chain[SYNC_STAGES-1];
    assign rise = s & ~s_d;

endmodule

`default_nettype wire

// File: rtl/interrupt_controller.sv
// =============================================================================
// interrupt_controller : synchronise, latch, mask and prioritise 8 interrupt
//                        lines into one request with ack/eret handshake
// Revision 1.0
// =============================================================================
`default_nettype none

module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ     = IRQ_LINES,
    parameter int SYNC_STAGES = 2
) (
    input  logic                ph1,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  interrupts,
    input  logic [NUM_IRQ-1:0]  edge_mode,
    input  logic [NUM_IRQ-1:0]  int_mask,
    input  logic                int_global_en,
    input  logic                ack,
    input  logic                eret,
    output logic                irq,
    output logic [IRQ_ID_W-1:0] irq_id,
    output logic [NUM_IRQ-1:0]  pending,
    output logic                in_service
);

    logic [NUM_IRQ-1:0]  sync_s;
    logic [NUM_IRQ-1:0]  sync_rise;
    logic [NUM_IRQ-1:0]  edge_pend;
    logic [NUM_IRQ-1:0]  edge_pend_next;
    logic [NUM_IRQ-1:0]  eligible;
    logic [NUM_IRQ-1:0]  clr;
    logic [IRQ_ID_W-1:0] sel;
    logic                ack_accept;

    irq_state_t          state;
    irq_state_t          state_next;
    logic                irq_next;
    logic [IRQ_ID_W-1:0] irq_id_next;
    logic                in_service_next;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .ph1   (ph1),
            .reset (reset),
            .din   (interrupts[g]),
            .s     (sync_s[g]),
            .rise  (sync_rise[g])
        );
    end

    // Level lines follow the synchroniser directly; only edge lines hold state.
    assign pending  = (edge_mode & edge_pend) | (~edge_mode & sync_s);
    assign eligible = pending & int_mask;
    assign ack_accept = (state == ST_REQ) && ack;

    always_comb begin
        sel = '0;
        clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i])
                sel = i[IRQ_ID_W-1:0];
            clr[i] = ack_accept && (irq_id == i[IRQ_ID_W-1:0]);
        end
        // A new edge in the same cycle as its ack keeps the line pending.
        edge_pend_next = edge_mode & (sync_rise | (edge_pend & ~clr));
    end

    always_comb begin
        state_next      = state;
        irq_next        = irq;
        irq_id_next     = irq_id;
        in_service_next = in_service;
        case (state)
            ST_IDLE: begin
                if ((|eligible) && int_global_en) begin
                    state_next  = ST_REQ;
                    irq_next    = 1'b1;
                    irq_id_next = sel;
                end
            end
            ST_REQ: begin
                if (ack) begin
                    state_next      = ST_SERVICE;
                    irq_next        = 1'b0;
                    in_service_next = 1'b1;
                end else if (!eligible[irq_id] || !int_global_en) begin
                    state_next = ST_IDLE;
                    irq_next   = 1'b0;
                end
            end
            ST_SERVICE: begin
                if (eret) begin
                    state_next      = ST_IDLE;
                    in_service_next = 1'b0;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                irq_next        = 1'b0;
                in_service_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            irq        <= 1'b0;
            irq_id     <= '0;
            in_service <= 1'b0;
            edge_pend  <= '0;
        end else begin
            state      <= state_next;
            irq        <= irq_next;
            irq_id     <= irq_id_next;
            in_service <= in_service_next;
            edge_pend  <= edge_pend_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_interrupt_controller.sv
// =============================================================================
// tb_interrupt_controller : directed self-checking bench for interrupt_controller
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_interrupt_controller;

    logic       ph1;
    logic       reset;
    logic [7:0] interrupts;
    logic [7:0] edge_mode;
    logic [7:0] int_mask;
    logic       int_global_en;
    logic       ack;
    logic       eret;
    logic       irq;
    logic [2:0] irq_id;
    logic [7:0] pending;
    logic       in_service;

    int checks = 0;
    int errors = 0;

    interrupt_controller dut (
        .ph1           (ph1),
        .reset         (reset),
        .interrupts    (interrupts),
        .edge_mode     (edge_mode),
        .int_mask      (int_mask),
        .int_global_en (int_global_en),
        .ack           (ack),
        .eret          (eret),
        .irq           (irq),
        .irq_id        (irq_id),
        .pending       (pending),
        .in_service    (in_service)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ph1);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic e_irq, input logic [2:0] e_id,
                           input logic [7:0] e_pend, input logic e_svc);
        chk({tag, ".irq"},        {31'd0, irq},        {31'd0, e_irq});
        chk({tag, ".irq_id"},     {29'd0, irq_id},     {29'd0, e_id});
        chk({tag, ".pending"},    {24'd0, pending},    {24'd0, e_pend});
        chk({tag, ".in_service"}, {31'd0, in_service}, {31'd0, e_svc});
    endtask

    initial begin
        reset = 1'b1; interrupts = '0; edge_mode = '0; int_mask = '0;
        int_global_en = 1'b0; ack = 1'b0; eret = 1'b0;
        #12;
        chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
        @(posedge ph1); #1;
        reset = 1'b0;

        // 1. idle with all inputs low
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_all("idle", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        // 2. single edge line 1, 50 ns pulse
        edge_mode = 8'hFF; int_mask = 8'hFF; int_global_en = 1'b1;
        interrupts = 8'h02;
        tick(2);
        chk_all("t2.sync", 1'b0, 3'd0, 8'h00, 1'b0);
        tick(1);
        chk_all("t2.pend", 1'b0, 3'd0, 8'h02, 1'b0);
        tick(1);
        chk_all("t2.irq", 1'b1, 3'd1, 8'h02, 1'b0);
        tick(1);
        interrupts = 8'h00;
        chk_all("t2.hold", 1'b1, 3'd1, 8'h02, 1'b0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_all("t2.ack", 1'b0, 3'd1, 8'h00, 1'b1);
        tick(1);
        chk_all("t2.svc", 1'b0, 3'd1, 8'h00, 1'b1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        chk_all("t2.eret", 1'b0, 3'd1, 8'h00, 1'b0);
        tick(2);
        chk_all("t2.quiet", 1'b0, 3'd1, 8'h00, 1'b0);

        // 3. lines 0 and 1 together: line 1 wins first
        interrupts = 8'h03;
        tick(4);
        chk_all("t3.irq1", 1'b1, 3'd1, 8'h03, 1'b0);
        interrupts = 8'h00;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_all("t3.ack1", 1'b0, 3'd1, 8'h01, 1'b1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        chk_all("t3.eret1", 1'b0, 3'd1, 8'h01, 1'b0);
        tick(1);
        chk_all("t3.irq0", 1'b1, 3'd0, 8'h01, 1'b0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_all("t3.ack0", 1'b0, 3'd0, 8'h00, 1'b1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(1);
        chk_all("t3.done", 1'b0, 3'd0, 8'h00, 1'b0);

        // 4. line 1 arrives during service of line 5
        interrupts = 8'h20;
        tick(4);
        chk_all("t4.irq5", 1'b1, 3'd5, 8'h20, 1'b0);
        interrupts = 8'h00;
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        chk_all("t4.svc5", 1'b0, 3'd5, 8'h00, 1'b1);
        interrupts = 8'h02;
        tick(4);
        interrupts = 8'h00;
        chk_all("t4.held", 1'b0, 3'd5, 8'h02, 1'b1);
        tick(2);
        chk_all("t4.held2", 1'b0, 3'd5, 8'h02, 1'b1);
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        chk_all("t4.eret", 1'b0, 3'd5, 8'h02, 1'b0);
        tick(1);
        chk_all("t4.irq1", 1'b1, 3'd1, 8'h02, 1'b0);
        ack = 1'b1;
        tick(1);
        ack = 1'b0;
        eret = 1'b1;
        tick(1);
        eret = 1'b0;
        tick(1);
        chk_all("t4.done", 1'b0, 3'd1, 8'h00, 1'b0);

        // 5. level line 3 withdrawn by mask
        edge_mode = 8'hF7;
        interrupts = 8'h08;
        tick(2);
        chk_all("t5.lvl", 1'b0, 3'd1, 8'h08, 1'b0);
        tick(1);
        chk_all("t5.irq3", 1'b1, 3'd3, 8'h08, 1'b0);
        int_mask = 8'hF7;
        tick(1);
        chk_all("t5.wdraw", 1'b0, 3'd3, 8'h08, 1'b0);
        tick(2);
        chk_all("t5.masked", 1'b0, 3'd3, 8'h08, 1'b0);
        interrupts = 8'h00;
        tick(3);
        int_mask = 8'hFF;
        edge_mode = 8'hFF;
        tick(1);
        chk_all("t5.done", 1'b0, 3'd3, 8'h00, 1'b0);

        // 6. reset while in REQ with lines 1 and 2 pending
        interrupts = 8'h06;
        tick(4);
        interrupts = 8'h00;
        chk_all("t6.req", 1'b1, 3'd2, 8'h06, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("t6.rst", 1'b0, 3'd0, 8'h00, 1'b0);
        @(posedge ph1); #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk_all("t6.after", 1'b0, 3'd0, 8'h00, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
